scara_motion_sequencer: RTL and testbench

SCARA_MOTION_SEQUENCER -- requirements
Module: scara_motion_sequencer

---
 rtl/scara_motion_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_scara_motion_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scara_motion_sequencer.sv
// SCARA motion sequencer: a small command FIFO feeds absolute/relative moves, pen and
// dwell commands; moves are issued to the stepper driver as bursts capped at 2^STEP_W-1.
module scara_motion_sequencer #(
  parameter int NAXES   = 2,
  parameter int POS_W   = 13,
  parameter int STEP_W  = 8,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 16,
  parameter int HOME    = 402
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [NAXES*POS_W-1:0]  cmd_data,
  input  logic                    abort,
  output logic                    step_valid,
  input  logic                    step_ready,
  output logic [NAXES*STEP_W-1:0] steps,
  output logic [NAXES-1:0]        dir,
  output logic                    pen,
  output logic [NAXES*POS_W-1:0]  pos,
  output logic                    busy,
  output logic                    cmd_done
);
  localparam int DW = NAXES * POS_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL     = (AW+1)'(DEPTH);
  localparam logic [POS_W:0] STEP_MAX = (POS_W+1)'((1 << STEP_W) - 1);

  typedef enum logic [1:0] {OP_ABS, OP_REL, OP_PEN, OP_DWELL} op_t;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DWELL, DONE} state_t;

  state_t             state;
  op_t                fifo_op   [DEPTH];
  logic [DW-1:0]      fifo_data [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  op_t                cur_op;
  logic [DW-1:0]      cur_data;
  logic [POS_W-1:0]   pos_q   [NAXES];
  logic [POS_W:0]     rem     [NAXES];
  logic [STEP_W-1:0]  steps_q [NAXES];
  logic [NAXES-1:0]   dir_q;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [POS_W-1:0]   tgt         [NAXES];
  logic [POS_W:0]     diff        [NAXES];
  logic [POS_W:0]     load_rem    [NAXES];
  logic [STEP_W-1:0]  load_steps  [NAXES];
  logic [POS_W:0]     burst_rem   [NAXES];
  logic [STEP_W-1:0]  burst_steps [NAXES];
  logic [POS_W-1:0]   burst_pos   [NAXES];
  logic [NAXES-1:0]   load_dir;
  logic               load_any, burst_any;
  logic               push, pop;

  assign cmd_ready  = (count != FULL);
  assign push       = cmd_valid && cmd_ready && !abort;
  assign pop        = (state == IDLE) && (count != '0) && !abort;
  assign step_valid = (state == ISSUE);
  assign cmd_done   = (state == DONE);
  assign busy       = (state != IDLE) || (count != '0);
  assign dir        = dir_q;

  for (genvar k = 0; k < NAXES; k++) begin : g_pack
    assign pos[k*POS_W +: POS_W]    = pos_q[k];
    assign steps[k*STEP_W +: STEP_W] = steps_q[k];
  end

  function automatic logic [STEP_W-1:0] cap(input logic [POS_W:0] r);
    return (r > STEP_MAX) ? STEP_MAX[STEP_W-1:0] : r[STEP_W-1:0];
  endfunction

  // Differences are taken one bit wider than a position so |target - pos| never overflows.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load_any  = 1'b0;
    burst_any = 1'b0;
    load_dir  = '0;
    for (int k = 0; k < NAXES; k++) begin
      tgt[k] = cur_data[k*POS_W +: POS_W];
      if (cur_op == OP_REL) tgt[k] = pos_q[k] + cur_data[k*POS_W +: POS_W];
      diff[k]        = {tgt[k][POS_W-1], tgt[k]} - {pos_q[k][POS_W-1], pos_q[k]};
      load_dir[k]    = !diff[k][POS_W] && (diff[k] != '0);
      load_rem[k]    = diff[k][POS_W] ? -diff[k] : diff[k];
      load_steps[k]  = cap(load_rem[k]);
      load_any       = load_any || (load_rem[k] != '0);
      burst_rem[k]   = rem[k] - (POS_W+1)'(steps_q[k]);
      burst_steps[k] = cap(burst_rem[k]);
      burst_any      = burst_any || (burst_rem[k] != '0);
      burst_pos[k]   = dir_q[k] ? pos_q[k] + POS_W'(steps_q[k])
                                : pos_q[k] - POS_W'(steps_q[k]);
    end
  end

  // NOTE: the storage array is not reset; count and pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= op_t'(cmd_op);
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur_op    <= OP_ABS;
      cur_data  <= '0;
      dir_q     <= '0;
      pen       <= 1'b0;
      dwell_cnt <= '0;
      for (int k = 0; k < NAXES; k++) begin
        pos_q[k]   <= POS_W'(HOME);
        rem[k]     <= '0;
        steps_q[k] <= '0;
      end
    end else if (abort) begin
      // A burst handshaken in the abort cycle is already on its way to the motors.
      if (step_valid && step_ready)
        for (int k = 0; k < NAXES; k++) pos_q[k] <= burst_pos[k];
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: if (pop) begin
          cur_op   <= fifo_op[rd_ptr];
          cur_data <= fifo_data[rd_ptr];
          state    <= LOAD;
        end
        LOAD: case (cur_op)
          OP_ABS, OP_REL: begin
            for (int k = 0; k < NAXES; k++) begin
              rem[k]     <= load_rem[k];
              steps_q[k] <= load_steps[k];
            end
            dir_q <= load_dir;
            state <= load_any ? ISSUE : DONE;
          end
          OP_PEN: begin
            pen   <= cur_data[0];
            state <= DONE;
          end
          OP_DWELL: begin
            dwell_cnt <= cur_data[DWELL_W-1:0];
            state     <= (cur_data[DWELL_W-1:0] == '0) ? DONE : DWELL;
          end
        endcase
        ISSUE: if (step_ready) begin
          for (int k = 0; k < NAXES; k++) begin
            pos_q[k]   <= burst_pos[k];
            rem[k]     <= burst_rem[k];
            steps_q[k] <= burst_steps[k];
          end
          state <= burst_any ? ISSUE : DONE;
        end
        DWELL: begin
          dwell_cnt <= dwell_cnt - 1'b1;
          if (dwell_cnt == DWELL_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scara_motion_sequencer.sv
// Bench for scara_motion_sequencer: a queue/integer model of the sequencer checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_scara_motion_sequencer;
  localparam int NAX = 2, PW = 13, SW = 8, DEPTH = 4, DWW = 16, HOME = 402;
  localparam int WAITING = 0, DECODING = 1, STEPPING = 2, PAUSING = 3, FINISHING = 4;

  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, abort, step_valid, step_ready, pen, busy, cmd_done;
  logic [1:0]        cmd_op;
  logic [NAX*PW-1:0] cmd_data, pos;
  logic [NAX*SW-1:0] steps;
  logic [NAX-1:0]    dir;

  always #5 clk = ~clk;

  scara_motion_sequencer #(
    .NAXES(NAX), .POS_W(PW), .STEP_W(SW), .DEPTH(DEPTH), .DWELL_W(DWW), .HOME(HOME)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .step_valid(step_valid),
    .step_ready(step_ready), .steps(steps), .dir(dir), .pen(pen), .pos(pos),
    .busy(busy), .cmd_done(cmd_done)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer positions, a command queue and a phase per command.
  typedef struct { logic [1:0] op; logic [NAX*PW-1:0] data; } cmd_t;
  cmd_t m_q[$];
  cmd_t m_cur, m_tmp;
  int   m_pos[NAX], m_rem[NAX];
  bit   m_dir[NAX];
  bit   m_pen, m_acc, m_room;
  int   m_phase, m_dwell;

  function automatic int field(input logic [NAX*PW-1:0] v, input int k);
    logic [PW-1:0] s;
    s = v[k*PW +: PW];
    return $signed(s);
  endfunction

  function automatic int wrap(input int v);
    int r;
    r = v % (1 << PW);
    if (r < 0) r += (1 << PW);
    if (r >= (1 << (PW-1))) r -= (1 << PW);
    return r;
  endfunction

  function automatic int burst_of(input int r);
    return (r > 255) ? 255 : r;
  endfunction

  function automatic bit all_done();
    for (int k = 0; k < NAX; k++) if (m_rem[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_burst();
    for (int k = 0; k < NAX; k++) begin
      int s;
      s = burst_of(m_rem[k]);
      m_pos[k] = m_dir[k] ? m_pos[k] + s : m_pos[k] - s;
      m_rem[k] = m_rem[k] - s;
    end
  endfunction

  function automatic void model_decode();
    case (m_cur.op)
      2'd0, 2'd1: begin
        for (int k = 0; k < NAX; k++) begin
          int t;
          t = (m_cur.op == 2'd0) ? field(m_cur.data, k) : wrap(m_pos[k] + field(m_cur.data, k));
          m_dir[k] = (t > m_pos[k]);
          m_rem[k] = (t > m_pos[k]) ? t - m_pos[k] : m_pos[k] - t;
        end
        m_phase = all_done() ? FINISHING : STEPPING;
      end
      2'd2: begin
        m_pen   = m_cur.data[0];
        m_phase = FINISHING;
      end
      default: begin
        m_dwell = int'(m_cur.data[DWW-1:0]);
        m_phase = (m_dwell == 0) ? FINISHING : PAUSING;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (!reset) begin
      m_q.delete();
      m_phase = WAITING;
      m_pen   = 1'b0;
      m_dwell = 0;
      for (int k = 0; k < NAX; k++) begin
        m_pos[k] = HOME; m_rem[k] = 0; m_dir[k] = 1'b0;
      end
    end else if (abort) begin
      if (m_phase == STEPPING && step_ready) model_burst();
      m_q.delete();
      m_phase = WAITING;
    end else begin
      m_room = (m_q.size() < DEPTH);
      case (m_phase)
        WAITING:  if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_phase = DECODING; end
        DECODING: model_decode();
        STEPPING: if (step_ready) begin
          model_burst();
          if (all_done()) m_phase = FINISHING;
        end
        PAUSING: begin
          m_dwell--;
          if (m_dwell == 0) m_phase = FINISHING;
        end
        default: m_phase = WAITING;
      endcase
      if (cmd_valid && m_room) begin
        m_tmp.op = cmd_op; m_tmp.data = cmd_data;
        m_q.push_back(m_tmp);
        m_acc = 1'b1;
      end
    end
  end

  function automatic logic [NAX*PW-1:0] exp_pos();
    logic [NAX*PW-1:0] r;
    for (int k = 0; k < NAX; k++) r[k*PW +: PW] = PW'(m_pos[k]);
    return r;
  endfunction

  function automatic logic [NAX*SW-1:0] exp_steps();
    logic [NAX*SW-1:0] r;
    for (int k = 0; k < NAX; k++) r[k*SW +: SW] = SW'(burst_of(m_rem[k]));
    return r;
  endfunction

  function automatic logic [NAX-1:0] exp_dir();
    logic [NAX-1:0] r;
    for (int k = 0; k < NAX; k++) r[k] = m_dir[k];
    return r;
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    check("step_valid", step_valid, m_phase == STEPPING);
    check("cmd_ready", cmd_ready, m_q.size() < DEPTH);
    check("busy", busy, (m_phase != WAITING) || (m_q.size() != 0));
    check("cmd_done", cmd_done, m_phase == FINISHING);
    check("pen", pen, m_pen);
    check("pos", pos, exp_pos());
    if (m_phase == STEPPING) begin
      check("steps", steps, exp_steps());
      check("dir", dir, exp_dir());
    end
  end

  // Observations of the DUT used by the directed literal checks.
  int n_done = 0, n_full = 0, cyc = 0;
  logic [SW-1:0] bursts[$];
  always @(negedge clk) begin
    if (step_valid && step_ready) bursts.push_back(steps[SW-1:0]);
    if (cmd_done) n_done++;
    if (!cmd_ready) n_full++;
  end
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [NAX*PW-1:0] d);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    do begin tick(); t++; end while (!m_acc && t < 100);
    cmd_valid = 1'b0;
    check("push_accepted", m_acc, 1'b1);
  endtask

  task automatic wait_phase(input int p);
    int t = 0;
    while (m_phase != p && t < 200) begin tick(); t++; end
    check("reach_phase", m_phase, p);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_phase != WAITING || m_q.size() != 0) && t < 3000) begin tick(); t++; end
    check("drained_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; abort = 1'b0; cmd_valid = 1'b0; step_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  int base, t, t_acc, t_done, t_pen;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    abort = 1'b0; step_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b1;
    check("reset_pos", pos, {13'd402, 13'd402});
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_steps", steps, 16'h0000);
    check("reset_dir", dir, 2'b00);
    check("reset_pen", pen, 1'b0);

    // Single burst move to {502,302}.
    step_ready = 1'b1;
    base = n_done;
    push_cmd(2'd0, {13'd302, 13'd502});
    wait_phase(STEPPING);
    check("abs_steps", steps, {8'd100, 8'd100});
    check("abs_dir", dir, 2'b01);
    wait_idle();
    check("abs_pos", pos, {13'd302, 13'd502});
    check("abs_done_count", n_done - base, 1);

    // 600-step move splits into 255, 255, 90.
    do_reset();
    step_ready = 1'b1;
    base = bursts.size();
    push_cmd(2'd0, {13'd402, 13'd1002});
    wait_idle();
    check("split_count", bursts.size() - base, 3);
    if (bursts.size() >= base + 3) begin
      check("split_b0", bursts[base], 8'd255);
      check("split_b1", bursts[base+1], 8'd255);
      check("split_b2", bursts[base+2], 8'd90);
    end
    check("split_pos", pos, {13'd402, 13'd1002});

    // Back-pressure: burst held stable for 20 cycles.
    do_reset();
    push_cmd(2'd0, {13'd432, 13'd352});
    wait_phase(STEPPING);
    repeat (20) begin
      check("hold_steps", steps, {8'd30, 8'd50});
      check("hold_dir", dir, 2'b10);
      check("hold_pos", pos, {13'd402, 13'd402});
      tick();
    end
    step_ready = 1'b1;
    wait_idle();
    check("hold_final_pos", pos, {13'd432, 13'd352});

    // Six commands: FIFO fills while the first move runs, all execute in order.
    do_reset();
    step_ready = 1'b1;
    base = n_done; t = n_full;
    push_cmd(2'd0, {13'd402, 13'd1002});
    push_cmd(2'd2, 26'd1);
    push_cmd(2'd1, {13'h1FF9, 13'd5});
    push_cmd(2'd3, 26'd3);
    push_cmd(2'd0, {13'h1F9C, 13'd100});
    push_cmd(2'd2, 26'd0);
    wait_idle();
    check("fifo_full_seen", (n_full - t) > 0, 1'b1);
    check("fifo_done_count", n_done - base, 6);
    check("fifo_final_pos", pos, {13'h1F9C, 13'd100});
    check("fifo_final_pen", pen, 1'b0);

    // Dwell 10 then pen up: completion timing.
    do_reset();
    push_cmd(2'd3, 26'd10);
    t_acc = cyc;
    push_cmd(2'd2, 26'd1);
    t = 0;
    while (!cmd_done && t < 100) begin tick(); t++; end
    t_done = cyc;
    while (!pen && t < 200) begin tick(); t++; end
    t_pen = cyc;
    check("dwell_done_latency", t_done - t_acc, 12);
    check("pen_after_done", t_pen - t_done, 3);
    wait_idle();

    // Abort during the second burst with three commands queued.
    do_reset();
    base = n_done;
    push_cmd(2'd0, {13'd402, 13'd1002});
    push_cmd(2'd2, 26'd1);
    push_cmd(2'd3, 26'd5);
    push_cmd(2'd1, {13'd0, 13'd1});
    wait_phase(STEPPING);
    step_ready = 1'b1; tick(); step_ready = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_step_valid", step_valid, 1'b0);
    check("abort_pos", pos, {13'd402, 13'd657});
    check("abort_pen", pen, 1'b0);
    check("abort_no_done", n_done - base, 0);
    tick();
    check("abort_busy_after", busy, 1'b0);

    // Abort coinciding with a handshake and a FIFO write.
    push_cmd(2'd0, {13'd402, 13'd1002});
    wait_phase(STEPPING);
    step_ready = 1'b1; abort = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 26'd1;
    tick();
    step_ready = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    check("abort_hs_pos", pos, {13'd402, 13'd912});
    check("abort_hs_busy", busy, 1'b0);
    check("abort_hs_pen", pen, 1'b0);
    tick();
    check("abort_hs_dropped", busy, 1'b0);

    // Reset mid-dwell wins over a concurrent command write.
    push_cmd(2'd3, 26'd50);
    repeat (5) tick();
    reset = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 26'd1;
    tick();
    reset = 1'b1; cmd_valid = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_pos", pos, {13'd402, 13'd402});
    check("rst_mid_pen", pen, 1'b0);

    // Zero-length move and zero dwell complete without bursts.
    base = n_done; t = bursts.size();
    push_cmd(2'd0, {13'd402, 13'd402});
    push_cmd(2'd3, 26'd0);
    wait_idle();
    check("zero_done_count", n_done - base, 2);
    check("zero_no_burst", bursts.size() - t, 0);

    // Relative move that wraps: 402 + 4000 -> -3790.
    step_ready = 1'b1;
    push_cmd(2'd1, {13'd0, 13'd4000});
    wait_idle();
    check("wrap_pos", pos, {13'd402, 13'h1132});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1);
  end
endmodule
